rx_frame_commit_ctrl: RTL
=========================

Name: rx_frame_commit_ctrl

Overview:
- Store-and-forward commit/discard controller between the RX MAC front end (GMII byte stream plus the one-cycle error pulse from the MAC error-invalidation logic) and the downstream parser/stream consumer.
- Writes each received frame into a circular byte buffer, holds it uncommitted until a post-frame error window has elapsed, then commits it for readout or rewinds the write pointer to discard it.
- Downstream only ever sees complete, error-free frames.

Parameters:
- DEPTH, 2048: buffer size in bytes; power of two, ≥64.
- ERR_WINDOW, 4: cycles after frame end during which a late error (CRC) still discards the frame; 1..8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- gmii_valid_i  in  1  RX data valid; high for the whole frame, low in the gap.
- gmii_data_i  in  8  RX byte.
- error_pulse_i  in  1  single-cycle error indication for the current/just-ended frame.
- out_valid_o  out  1  committed byte available.
- out_data_o  out  8  output byte.
- out_last_o  out  1  final byte of frame.
- out_ready_i  in  1  downstream accept.
- frame_committed_o  out  1  pulse: frame committed.
- frame_dropped_o  out  1  pulse: frame discarded (error or overflow).
- overflow_o  out  1  pulse: discard caused by buffer full.
- drop_cnt_o  out  16  saturating count of dropped frames.

Behaviour:
- Reset: all pointers 0, state IDLE, skid register empty, every output 0, drop_cnt_o = 0.
- Pointers: wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits and wrapping naturally.
- Occupancy is wr_ptr−rd_ptr and includes uncommitted bytes. Buffer entry = {last, data}, 9 bits.
- Skid register: a byte captured in cycle t is written in t+1, with last=0 if gmii_valid_i is still high and last=1 if it is low. Let E = first cycle with gmii_valid_i low after a frame; the last byte is written in E.
- Write-side FSM:
  - IDLE: on gmii_valid_i high, capture byte and go to RECV. error_pulse_i is ignored here.
  - RECV: write the skid byte each cycle per the rule above.
    - error_pulse_i in RECV (including cycle E): wr_ptr <= commit_ptr and frame_dropped_o=1; go to DROP if gmii_valid_i is high, else IDLE.
    - Write attempted with occupancy == DEPTH: same rewind, plus overflow_o=1; go to DROP, or IDLE if valid is low.
    - Cycle E with no error: go to PEND with cnt=ERR_WINDOW.
  - PEND: decrement cnt each cycle.
    - error_pulse_i: rewind, dropped pulse, go to IDLE.
    - cnt==1 with no error: commit_ptr <= wr_ptr, frame_committed_o=1, go to IDLE.
    - Timing: commit takes effect at the end of cycle E+ERR_WINDOW; out_valid_o can first rise at E+ERR_WINDOW+1.
    - gmii_valid_i high during PEND: resolve the pending frame that cycle (commit, or rewind if the error pulse is present), then capture the new byte and go to RECV.
  - DROP: discard bytes and ignore error_pulse_i until gmii_valid_i is low, then go to IDLE.
- Read side:
  - out_valid_o = (rd_ptr != commit_ptr). Data and last come from entry rd_ptr; rd_ptr increments on out_valid_o && out_ready_i.
  - Output data is registered/first-word-fall-through and must be stable while valid && !ready.
  - A commit and a read in the same cycle are both honoured.
- drop_cnt_o increments on every frame_dropped_o and saturates at 0xFFFF.
- All pulse outputs are single-cycle and registered. frame_committed_o and frame_dropped_o are never high together.
- Asserting rst_n low mid-frame clears everything, including committed but unread data. The remainder of an in-flight frame after reset release is treated as a new frame from the next valid cycle; the MAC guarantees a preamble-based restart.

Test Plan:
- 64-byte clean frame, ERR_WINDOW=4, out_ready_i=1:
  - frame_committed_o at E+4, out_valid_o from E+5.
  - 64 bytes out in order; out_last_o only on byte 64; drop_cnt_o=0.
- 100-byte frame with error_pulse_i at byte 40:
  - frame_dropped_o pulses; DROP until valid falls; no output.
  - Next clean 60-byte frame is output intact from the old commit_ptr.
- Late CRC error_pulse_i at E+2:
  - Frame discarded, wr_ptr == commit_ptr, out_valid_o stays 0, drop_cnt_o=1.
- DEPTH=64, out_ready_i=0, 40-byte frame committed, then 40-byte frame:
  - Second frame gets overflow_o + frame_dropped_o at its 25th byte.
  - First frame is still read out intact once ready=1.
- Back-to-back: new frame valid at E+2 (ERR_WINDOW=4):
  - Pending frame commits at E+2 and the new frame is captured; both read out correctly.
  - Repeat with error_pulse_i at E+2: only the second frame is output.
- Wrap-around and backpressure: 50 random-length frames with random out_ready_i:
  - Pointers wrap; scoreboard shows every clean frame byte-exact.
  - drop_cnt_o equals the number of injected errors.

Source files
------------

// File: rtl/rx_frame_commit_ctrl.sv
`timescale 1ns/1ps
// Store-and-forward RX frame buffer. A frame is held uncommitted until the
// late-error window closes, then it is either committed to the reader or rewound away.
module rx_frame_commit_ctrl #(
  parameter int DEPTH      = 2048,
  parameter int ERR_WINDOW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_valid_i,
  input  logic [7:0]  gmii_data_i,
  input  logic        error_pulse_i,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        frame_committed_o,
  output logic        frame_dropped_o,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(ERR_WINDOW + 1);

  typedef enum logic [1:0] {IDLE, RECV, PEND, DROP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  logic [7:0]    skid_q;
  logic [8:0]    rdat_q;
  logic          cmt_q, drp_q, ovf_q;
  logic [15:0]   dcnt_q;
  logic          full, wr_en, rewind, commit, ovf;
  logic [8:0]    mem [DEPTH];

  // Occupancy counts uncommitted bytes too, so a long frame cannot overrun unread data.
  assign full = (wr_q - rd_q) == PW'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (gmii_valid_i) state_d = RECV;
      RECV: begin
        if (rewind) state_d = gmii_valid_i ? DROP : IDLE;
        else if (!gmii_valid_i) begin
          state_d = PEND;
          cnt_d   = CW'(ERR_WINDOW);
        end
      end
      PEND: begin
        cnt_d = cnt_q - CW'(1);
        if (gmii_valid_i)          state_d = RECV;
        else if (rewind || commit) state_d = IDLE;
      end
      DROP: if (!gmii_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en  = 1'b0;
    rewind = 1'b0;
    commit = 1'b0;
    ovf    = 1'b0;
    case (state_q)
      RECV: begin
        if (error_pulse_i) rewind = 1'b1;
        else if (full) begin
          rewind = 1'b1;
          ovf    = 1'b1;
        end
        else wr_en = 1'b1;
      end
      // A new frame arriving early forces the pending one to resolve now.
      PEND: begin
        if (error_pulse_i)                          rewind = 1'b1;
        else if (cnt_q == CW'(1) || gmii_valid_i)   commit = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_d        = rewind ? cm_q : wr_q + PW'(wr_en);
  assign cm_d        = commit ? wr_q : cm_q;
  assign out_valid_o = rd_q != cm_q;
  assign rd_d        = rd_q + PW'(out_valid_o && out_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wr_q   <= '0;
      cm_q   <= '0;
      rd_q   <= '0;
      skid_q <= '0;
      rdat_q <= '0;
      cmt_q  <= 1'b0;
      drp_q  <= 1'b0;
      ovf_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      skid_q <= gmii_data_i;
      // Prefetch the next head entry; it is always written at least one cycle before commit.
      rdat_q <= mem[rd_d[AW-1:0]];
      cmt_q  <= commit;
      drp_q  <= rewind;
      ovf_q  <= ovf;
      if (rewind && dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= {~gmii_valid_i, skid_q};
  end

  assign out_data_o        = out_valid_o ? rdat_q[7:0] : 8'h00;
  assign out_last_o        = out_valid_o & rdat_q[8];
  assign frame_committed_o = cmt_q;
  assign frame_dropped_o   = drp_q;
  assign overflow_o        = ovf_q;
  assign drop_cnt_o        = dcnt_q;
endmodule
